// File: rtl/seg7_ctrl_pkg.sv
// seg7_ctrl_pkg: shared state encoding, word width and counter sizing for the display arbiter
package seg7_ctrl_pkg;
  typedef enum logic {IDLE, SHOW} state_t;
  localparam int MSG_W = 32;
  function automatic int cnt_width(input int hold);
    return $clog2(hold + 1);
  endfunction
endpackage

// File: rtl/seg7_prio_enc.sv
// seg7_prio_enc: highest-set-bit encoder, shared by idle grant and preemption compare
module seg7_prio_enc #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  output logic               any_valid,
  output logic [2:0]         idx
);
  // later iterations overwrite earlier ones, so the highest set index wins
  always_comb begin
    any_valid = |req;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (req[i]) idx = 3'(i);
  end
endmodule

// File: rtl/seg7_msg_arbiter.sv
// seg7_msg_arbiter: fixed-priority sharing of the 8-digit display with a per-message dwell time
module seg7_msg_arbiter
  import seg7_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [MSG_W*NUM_REQ-1:0] req_data,
  input  logic [MSG_W-1:0]         idle_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     done,
  output logic [2:0]               active_src,
  output logic                     busy,
  output logic [MSG_W-1:0]         x_out
);
  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [MSG_W-1:0] x_d, sel_word;
  logic [NUM_REQ-1:0] ack_d;
  logic done_d, busy_d, any_valid, expire, grant;
  logic [2:0] idx, src_d;
  seg7_prio_enc #(.NUM_REQ(NUM_REQ)) u_enc (
    .req(req),
    .any_valid(any_valid),
    .idx(idx)
  );
  assign expire = (state == SHOW) && (cnt == '0);
  assign grant  = any_valid && ((state == IDLE) || expire || (idx > active_src));
  // pick the word of the winning requester
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) if (idx == 3'(i)) sel_word = req_data[i*MSG_W +: MSG_W];
  end
  // next state: grant (new, back-to-back or preempting), fall back to idle on expiry, else count down
  always_comb begin
    state_d = state;
    x_d = x_out;
    cnt_d = cnt;
    ack_d = '0;
    done_d = 1'b0;
    busy_d = busy;
    src_d = active_src;
    if (grant) begin
      state_d = SHOW;
      x_d = sel_word;
      cnt_d = RELOAD;
      ack_d = NUM_REQ'(1) << idx;
      busy_d = 1'b1;
      src_d = idx;
      done_d = (state == SHOW);
    end else if ((state == IDLE) || expire) begin
      state_d = IDLE;
      x_d = idle_data;
      busy_d = 1'b0;
      done_d = expire;
    end else begin
      cnt_d = cnt - CNT_W'(1);
    end
  end
  // all outputs are registered; reset abandons any message without a done pulse
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      x_out <= '0;
      cnt <= '0;
      ack <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      active_src <= '0;
    end else begin
      state <= state_d;
      x_out <= x_d;
      cnt <= cnt_d;
      ack <= ack_d;
      done <= done_d;
      busy <= busy_d;
      active_src <= src_d;
    end
  end
endmodule

// File: tb/tb_seg7_msg_arbiter.sv
// tb_seg7_msg_arbiter: vector table plus hand sequences for preemption, queuing and reset
module tb_seg7_msg_arbiter;
  localparam int N = 4;
  localparam int H = 8;
  localparam logic [31:0] D0 = 32'hA000_0000, D1 = 32'hDEAD_BEEF, D2 = 32'hC000_0002, D3 = 32'hE000_0001;
  localparam logic [31:0] IDL = 32'h0000_1234;
  typedef struct {
    logic [3:0] req;
    logic [31:0] x;
    logic [3:0] ack;
    logic done;
    logic busy;
    logic [2:0] src;
  } vec_t;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [32*N-1:0] req_data = {D3, D2, D1, D0};
  logic [31:0] idle_data = IDL;
  logic [N-1:0] ack;
  logic done, busy;
  logic [2:0] active_src;
  logic [31:0] x_out;
  int tests = 0, fails = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  seg7_msg_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .req(req),
    .req_data(req_data),
    .idle_data(idle_data),
    .ack(ack),
    .done(done),
    .active_src(active_src),
    .busy(busy),
    .x_out(x_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic [3:0] r, input logic [31:0] x, input logic [3:0] a, input logic d,
                     input logic b, input logic [2:0] s);
    vec_t v;
    v.req = r; v.x = x; v.ack = a; v.done = d; v.busy = b; v.src = s;
    vecs.push_back(v);
  endtask
  task automatic check_all(input string tag, input vec_t e);
    check({tag, " x_out"}, x_out, e.x);
    check({tag, " ack"}, 32'(ack), 32'(e.ack));
    check({tag, " done"}, 32'(done), 32'(e.done));
    check({tag, " busy"}, 32'(busy), 32'(e.busy));
    if (e.busy) check({tag, " active_src"}, 32'(active_src), 32'(e.src));
  endtask
  initial begin
    vec_t e;
    // single message from src 1, full dwell, then back to idle
    add(4'b0010, D1, 4'b0010, 0, 1, 1);
    for (int i = 0; i < H - 1; i++) add(4'b0000, D1, 4'b0000, 0, 1, 1);
    add(4'b0000, IDL, 4'b0000, 1, 0, 1);
    add(4'b0000, IDL, 4'b0000, 0, 0, 1);
    // src 0 and 2 together: src 2 first, src 0 back-to-back at expiry
    add(4'b0101, D2, 4'b0100, 0, 1, 2);
    for (int i = 0; i < H - 1; i++) add(4'b0001, D2, 4'b0000, 0, 1, 2);
    add(4'b0001, D0, 4'b0001, 1, 1, 0);
    for (int i = 0; i < H - 1; i++) add(4'b0000, D0, 4'b0000, 0, 1, 0);
    add(4'b0000, IDL, 4'b0000, 1, 0, 0);
    // reset behaviour and first idle word
    step(); step();
    check("reset x_out", x_out, 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset ack", 32'(ack), 32'h0);
    clr_n = 1'b1;
    step();
    check("idle x_out", x_out, IDL);
    check("idle busy", 32'(busy), 32'h0);
    foreach (vecs[i]) begin
      req = vecs[i].req;
      exp_q.push_back(vecs[i]);
      step();
      e = exp_q.pop_front();
      check_all($sformatf("vec%0d", i), e);
    end
    // preemption of src 1 at count 5 by src 3
    req = 4'b0010;
    step();
    check("pre grant1 ack", 32'(ack), 32'h2);
    req = 4'b0000;
    step(); step();
    req = 4'b1000;
    step();
    check("pre ack3", 32'(ack), 32'h8);
    check("pre done", 32'(done), 32'h1);
    check("pre x_out", x_out, D3);
    check("pre src", 32'(active_src), 32'h3);
    req = 4'b0000;
    for (int i = 0; i < H - 1; i++) begin
      step();
      check($sformatf("pre hold%0d x_out", i), x_out, D3);
      check($sformatf("pre hold%0d done", i), 32'(done), 32'h0);
    end
    step();
    check("pre end done", 32'(done), 32'h1);
    check("pre end x_out", x_out, IDL);
    check("pre end busy", 32'(busy), 32'h0);
    // lower priority request waits for expiry
    req = 4'b0100;
    step();
    check("wait ack2", 32'(ack), 32'h4);
    req = 4'b0010;
    for (int i = 0; i < H - 1; i++) begin
      step();
      check($sformatf("wait%0d ack", i), 32'(ack), 32'h0);
      check($sformatf("wait%0d x_out", i), x_out, D2);
    end
    step();
    check("wait ack1", 32'(ack), 32'h2);
    check("wait done", 32'(done), 32'h1);
    check("wait x_out", x_out, D1);
    req = 4'b0000;
    for (int i = 0; i < H; i++) step();
    check("wait idle x_out", x_out, IDL);
    // asynchronous reset mid-message
    req = 4'b1000;
    step();
    req = 4'b0000;
    step(); step(); step();
    check("mid x_out", x_out, D3);
    #2 clr_n = 1'b0;
    #1;
    check("async x_out", x_out, 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async done", 32'(done), 32'h0);
    step();
    check("held done", 32'(done), 32'h0);
    idle_data = 32'h0000_5678;
    clr_n = 1'b1;
    step();
    check("post x_out", x_out, 32'h0000_5678);
    check("post busy", 32'(busy), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_msg_arbiter.md
Name: seg7_msg_arbiter

Overview:
Shares the single 8-digit 7-segment display driver (seg7decimal) between several ATM requesters: PIN entry, balance, error/status messages and so on. Each requester posts a 32-bit hex word; the arbiter grants by fixed priority and holds the granted word on the display for a programmable dwell time. When no message is active it shows a live idle word. Its x_out drives the driver's 32-bit x input directly.

Parameters:
NUM_REQ, 4, number of requesters; index NUM_REQ-1 has highest priority; legal range 2..8.
HOLD_CYCLES, 100_000_000, dwell time in clk cycles (1 s at 100 MHz); minimum legal value 1.
CNT_W, $clog2(HOLD_CYCLES+1), localparam; width of the dwell counter.

Ports:
clk  in  1  system clock
clr_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester level request; held until the matching ack
req_data  in  32*NUM_REQ  message words; requester i occupies bits [32*i+31:32*i]
idle_data  in  32  word shown while idle; sampled every cycle
ack  out  NUM_REQ  one-hot, one-cycle pulse when a request is granted
done  out  1  one-cycle pulse when a granted message finishes its dwell or is preempted
active_src  out  3  index of the requester currently shown; valid only while busy=1
busy  out  1  high in SHOW state
x_out  out  32  registered word sent to the display driver

Behaviour:
- Reset (clr_n=0, async): state=IDLE, x_out=0, ack=0, done=0, busy=0, active_src=0, counter=0.
- State IDLE:
  - No request pending: x_out<=idle_data every cycle (one-cycle latency).
  - Any req bit high at edge N: grant the highest set index g. At edge N, x_out<=req_data[g], ack[g]=1 for cycle N..N+1, counter<=HOLD_CYCLES-1, state<=SHOW, active_src<=g, busy<=1.
- State SHOW:
  - x_out holds the latched word. A requester changing req_data after ack has no effect.
  - Counter decrements by 1 per cycle.
- Expiry (counter==0 in SHOW):
  - done pulses for one cycle.
  - If any req is pending, grant the highest one at the same edge, with no idle cycle in between; this includes re-granting the same source if its req is still high.
  - Otherwise state<=IDLE and x_out<=idle_data at that edge.
- Preemption: in SHOW, a req at an index strictly greater than active_src causes an immediate grant at that edge. The counter restarts at HOLD_CYCLES-1 and done pulses for the preempted message. Requests at equal or lower priority wait for expiry.
- ack is never asserted for a source whose req is low. At most one ack bit is high per cycle.
- Requester rule: drop req the cycle after ack. A req still high then is treated as a new request.
- HOLD_CYCLES=1: each message is shown exactly one cycle.
- Reset mid-SHOW: the message is abandoned, no done pulse, outputs go to reset values.
- Total dwell of an unpreempted message: exactly HOLD_CYCLES cycles of x_out, from the grant edge to the expiry edge.

Decomposition:
- Package seg7_ctrl_pkg: state enum {IDLE, SHOW}, MSG_W=32 constant, function for counter width.
- Sub-module seg7_prio_enc: combinational highest-set-bit encoder over NUM_REQ. Outputs any_valid and the 3-bit index. It is used for both IDLE grant and the preemption compare.
- The top level holds the FSM, dwell counter, data mux and output registers.

Test Plan (HOLD_CYCLES=8, NUM_REQ=4):
1. Reset, then idle_data=32'h0000_1234, no req -> x_out=0 during reset; x_out=32'h0000_1234 one cycle after reset release; busy=0.
2. req[1] pulsed with data 32'hDEAD_BEEF -> ack[1] one cycle; x_out=DEADBEEF for exactly 8 cycles; done pulses on the 8th; x_out returns to idle_data on the next edge.
3. req[0] and req[2] raised in the same cycle -> ack[2] first and its word shown 8 cycles; then ack[0] immediately on expiry with no idle cycle; two done pulses in total.
4. During SHOW of src 1 at count 5, raise req[3] (data 32'hE000_0001) -> ack[3] and done the same cycle; x_out=E0000001 for a full 8 cycles; active_src=3.
5. During SHOW of src 2, raise req[1] -> no ack until src 2 expires; then ack[1] at expiry.
6. Assert clr_n=0 mid-SHOW -> x_out=0 and busy=0 immediately (async), no done pulse; after release, x_out shows idle_data.
